audio_dac_out: RTL and testbench
================================

# audio_dac_out

Output stage of the SID audio path. Consumes the filter/volume block's 8-bit offset-binary sample stream (`sample_in` + one-cycle `sample_valid`) and drives a single 1-bit pin as either fixed-period PWM or first-order sigma-delta, for an external RC low-pass. Double-buffers samples to PWM period boundaries, ramps softly from 0 to midscale after reset to avoid a pop, and flags sample underrun.

## Interface
- `UNDERRUN_PERIODS`, default 4: consecutive boundaries without a new sample that set `underrun` (1..15).
- `clk`: in, 1 bit. Single clock domain.
- `rst`: in, 1 bit. Asynchronous, active-high reset.
- `sample_in`: in, 8 bits. Unsigned offset-binary sample; 0x80 is midscale.
- `sample_valid`: in, 1 bit. Single-cycle strobe qualifying `sample_in`.
- `sd_mode`: in, 1 bit. 0 selects PWM; 1 selects sigma-delta. Sampled at period boundaries.
- `underrun_clr`: in, 1 bit. Clears the sticky `underrun` flag.
- `audio_out`: out, 1 bit. Registered modulator output.
- `period_strobe`: out, 1 bit. High for the one cycle in which `cnt == 0`.
- `underrun`: out, 1 bit. Sticky underrun flag.

## Operation
- **Reset state.** `cnt`=0, `active`=0, `pend`=0, `pend_full`=0, `miss`=0, `acc`=0, `mode_q`=0, state RAMP. Outputs `audio_out`=0, `period_strobe`=0, `underrun`=0.
- **Period counter.** 8-bit `cnt` free-runs 0..255 and wraps. The "boundary" is the clock edge on which `cnt == 255`.
- **Pending register.**
  - On `sample_valid`: `pend <= sample_in`, `pend_full <= 1`.
  - A later sample in the same period overwrites; newest wins.
- **RAMP state.**
  - At each boundary, `active <= active + 1`.
  - At the boundary where `active == 0x7F`: `active <= 0x80` and state <= RUN. The ramp lasts 128 periods.
  - Samples are captured into `pend` but never loaded during RAMP. `miss` is not counted.
- **RUN state, at each boundary:**
  - If `sample_valid` is high on the boundary edge: `active <= sample_in`, `pend_full <= 0`. The incoming sample bypasses `pend`.
  - Else if `pend_full`: `active <= pend`, `pend_full <= 0`.
  - Else `active` holds its value. `miss` increments, saturating at 15.
  - Any load clears `miss` to 0.
- **Underrun.**
  - `underrun <= 1` whenever `miss` reaches `UNDERRUN_PERIODS`.
  - `underrun_clr` clears it. If set and clear coincide, set wins.
- **Mode latch.**
  - At each boundary, `mode_q <= sd_mode`.
  - If `mode_q` changes value at that boundary, `acc` is cleared on the same edge.
- **PWM** (`mode_q == 0`): `audio_out <= (cnt < active)`.
  - Duty is `active`/256.
  - `active == 0` gives a constant 0.
  - `active == 0xFF` gives 255 high cycles per 256.
- **Sigma-delta** (`mode_q == 1`): each cycle, `sum = {1'b0, acc} + active` (9 bits); `acc <= sum[7:0]`; `audio_out <= sum[8]`.
  - Pulse density is `active`/256.
  - `acc` persists across boundaries.
- **Reset mid-operation.** All state clears immediately and asynchronously. The ramp restarts from 0, and a pending sample is discarded.

## Timing
- Period: 256 `clk` cycles. Sustainable sample rate: one sample per period; extra samples are dropped (overwritten).
- Latency from `sample_valid` to effect:
  - The sample loads at the next boundary.
  - `active` holds the new value in the `cnt == 0` cycle.
  - `audio_out` reflects it from the `cnt == 1` cycle, because of the 1-cycle output register.
  - Worst case: 257 cycles.
- PWM high pulse: for `active` = N, `audio_out` is high exactly N contiguous cycles, starting at the cycle after `cnt == 0`.
- `period_strobe` aligns with the first cycle of each period in both states.
- Reset release: the first boundary is 256 cycles after reset deassertion. RUN is entered after 128 boundaries, i.e. 32768 cycles.

## Structure
- Shared package `sid_audio_pkg`:
  - `SAMPLE_W` = 8.
  - `MIDSCALE` = 8'h80.
  - State enum `dac_state_t` with values `RAMP` and `RUN`.
- One sub-module, `sd_mod1`: 8-bit first-order accumulator with a synchronous clear. Inputs: `clk`, `rst`, `clr`, `level[7:0]`. Output: `bit_out`.
- Counter, buffering, FSM, underrun logic and the PWM comparator live in the top level.

## Test plan
1. **Soft start, then starvation.** Reset, no samples.
   - `audio_out` = 0 throughout period 0.
   - After 128 boundaries: state RUN, `active` = 0x80, exactly 128 high cycles per period.
   - `underrun` rises at the 4th boundary after RUN entry.
2. **Steady PWM.** In RUN with `sd_mode` = 0, send 0x40 once per period.
   - Exactly 64 contiguous high cycles per period, starting at `cnt` = 1.
   - `underrun` stays 0.
3. **Newest sample wins.** Send 0x10 then 0xF0 within one period.
   - The next period has 240 high cycles.
   - 0x10 never appears on the output.
4. **Sample on the boundary edge.** Assert `sample_valid` with 0x20 on the cycle where `cnt == 255`.
   - The following period has 32 high cycles.
   - `pend_full` = 0 afterwards.
5. **Sigma-delta density.** Set `sd_mode` = 1.
   - With `active` = 0x80: the output alternates 1,0 after the boundary-aligned `acc` clear.
   - With `active` = 0x40: exactly one high every 4 cycles, 64 per 256.
6. **Reset and clear corner cases.**
   - Pulse `rst` mid-period in RUN: `audio_out`, `underrun`, `active` go to 0 immediately, and the ramp restarts.
   - Assert `underrun_clr` on the same edge as an underrun set: `underrun` remains 1.

Source files
------------

// File: rtl/sid_audio_pkg.sv
// Shared constants and types for the SID audio output path.
package sid_audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;

  typedef enum logic {
    RAMP = 1'b0,
    RUN  = 1'b1
  } dac_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'h1;
  endfunction

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta accumulator; the carry out of the 9-bit sum is the bit.
module sd_mod1
  import sid_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [SAMPLE_W-1:0] level,
  output logic                bit_out
);

  logic [SAMPLE_W:0]   w_sum;
  logic [SAMPLE_W-1:0] r_acc;

  assign w_sum   = {1'b0, r_acc} + {1'b0, level};
  assign bit_out = w_sum[SAMPLE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sum[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_dac_out.sv
// SID audio output stage: period-aligned sample buffering, soft-start ramp,
// underrun detection and a PWM / sigma-delta 1-bit modulator.
module audio_dac_out
  import sid_audio_pkg::*;
#(
  parameter int unsigned UNDERRUN_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                sd_mode,
  input  logic                underrun_clr,
  output logic                audio_out,
  output logic                period_strobe,
  output logic                underrun
);

  localparam logic [3:0] MISS_LIMIT = 4'(UNDERRUN_PERIODS);

  logic [7:0]          r_cnt;
  logic [SAMPLE_W-1:0] r_active;
  logic [SAMPLE_W-1:0] r_pend;
  logic                r_pend_full;
  logic [3:0]          r_miss;
  logic                r_mode_q;
  dac_state_t          r_state;

  logic       w_boundary;
  logic       w_run_bnd;
  logic       w_load_now;
  logic       w_load_pend;
  logic       w_starve;
  logic [3:0] w_miss_nxt;
  logic       w_ur_set;
  logic       w_mode_chg;
  logic       w_pwm_bit;
  logic       w_sd_bit;

  assign w_boundary  = (r_cnt == 8'hFF);
  assign w_run_bnd   = w_boundary && (r_state == RUN);
  // A sample arriving on the boundary edge itself bypasses the pending register.
  assign w_load_now  = w_run_bnd && sample_valid;
  assign w_load_pend = w_run_bnd && !sample_valid && r_pend_full;
  assign w_starve    = w_run_bnd && !sample_valid && !r_pend_full;
  assign w_miss_nxt  = sat_inc4(r_miss);
  assign w_ur_set    = w_starve && (w_miss_nxt == MISS_LIMIT);
  assign w_mode_chg  = w_boundary && (sd_mode != r_mode_q);
  assign w_pwm_bit   = (r_cnt < r_active);

  sd_mod1 u_sd_mod1 (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_mode_chg),
    .level   (r_active),
    .bit_out (w_sd_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'h00;
    end else begin
      r_cnt <= r_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_pend <= sample_in;
      end
      if (w_load_now || w_load_pend) begin
        r_pend_full <= 1'b0;
      end else if (sample_valid) begin
        r_pend_full <= 1'b1;
      end
    end
  end

  // Ramp 0 -> midscale over 128 periods, then follow the sample stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      r_state  <= RAMP;
    end else if (w_boundary) begin
      case (r_state)
        RAMP: begin
          if (r_active == MIDSCALE - 8'h01) begin
            r_active <= MIDSCALE;
            r_state  <= RUN;
          end else begin
            r_active <= r_active + 8'h01;
          end
        end
        RUN: begin
          if (w_load_now) begin
            r_active <= sample_in;
          end else if (w_load_pend) begin
            r_active <= r_pend;
          end
        end
        default: begin
          r_active <= '0;
          r_state  <= RAMP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss   <= 4'h0;
      underrun <= 1'b0;
    end else begin
      if (w_load_now || w_load_pend) begin
        r_miss <= 4'h0;
      end else if (w_starve) begin
        r_miss <= w_miss_nxt;
      end
      if (w_ur_set) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q      <= 1'b0;
      audio_out     <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      if (w_boundary) begin
        r_mode_q <= sd_mode;
      end
      audio_out     <= r_mode_q ? w_sd_bit : w_pwm_bit;
      period_strobe <= w_boundary;
    end
  end

endmodule

// File: tb/tb_audio_dac_out.sv
// Self-checking bench for audio_dac_out: per-cycle model comparison plus
// hand-computed period measurements.
module tb_audio_dac_out;
  import sid_audio_pkg::*;

  localparam int UR = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sd_mode;
  logic       underrun_clr;
  logic       audio_out;
  logic       period_strobe;
  logic       underrun;

  int errors;
  int n_checks;

  audio_dac_out #(.UNDERRUN_PERIODS(UR)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sd_mode       (sd_mode),
    .underrun_clr  (underrun_clr),
    .audio_out     (audio_out),
    .period_strobe (period_strobe),
    .underrun      (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] active;
    logic [7:0] pend;
    logic [7:0] acc;
    logic       full;
    logic [3:0] miss;
    logic       mode;
    logic       run;
    logic       ur;
    logic       out;
    logic       strobe;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t s, input logic vld, input logic [7:0] din,
                                        input logic sdm, input logic clr);
    model_t n;
    int     sum;
    logic   bnd;
    logic   set_ur;
    n      = s;
    set_ur = 1'b0;
    bnd    = (s.cnt == 8'd255);
    n.cnt  = 8'((int'(s.cnt) + 1) % 256);
    n.strobe = bnd;
    if (s.mode) begin
      sum   = int'(s.acc) + int'(s.active);
      n.out = (sum >= 256);
      n.acc = 8'(sum % 256);
    end else begin
      n.out = (int'(s.cnt) < int'(s.active));
    end
    if (vld) begin
      n.pend = din;
      n.full = 1'b1;
    end
    if (bnd) begin
      if (!s.run) begin
        n.active = 8'(int'(s.active) + 1);
        n.run    = (s.active == 8'd127);
      end else if (vld) begin
        n.active = din;
        n.full   = 1'b0;
        n.miss   = 4'd0;
      end else if (s.full) begin
        n.active = s.pend;
        n.full   = 1'b0;
        n.miss   = 4'd0;
      end else begin
        n.miss = (s.miss == 4'd15) ? 4'd15 : 4'(int'(s.miss) + 1);
        set_ur = (int'(n.miss) == UR);
      end
      n.mode = sdm;
      if (sdm != s.mode) n.acc = 8'd0;
    end
    if (set_ur) n.ur = 1'b1;
    else if (clr) n.ur = 1'b0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, sample_valid, sample_in, sd_mode, underrun_clr);
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    n_checks <= n_checks + 1;
    if ({audio_out, period_strobe, underrun} !== {m.out, m.strobe, m.ur}) begin
      errors <= errors + 1;
      $display("FAIL cycle_cmp t=%0t cnt=%0d out/strobe/ur got %b%b%b expected %b%b%b",
               $time, m.cnt, audio_out, period_strobe, underrun, m.out, m.strobe, m.ur);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go_to(input logic [7:0] c);
    int b;
    b = 0;
    while (m.cnt != c && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (m.cnt != c) begin
      n_checks = n_checks + 1;
      errors   = errors + 1;
      $display("FAIL go_to_timeout: got cnt %0d expected %0d", m.cnt, c);
    end
  endtask

  // Observe audio_out over cnt 1..255 and the following cnt 0, optionally
  // strobing up to two samples at given cnt values in the window.
  task automatic measure(input int s1, input logic [7:0] v1, input int s2, input logic [7:0] v2,
                         output int highs, output int first, output int runs);
    logic prev;
    highs = 0;
    first = -1;
    runs  = 0;
    prev  = 1'b0;
    go_to(8'd1);
    for (int k = 1; k <= 256; k++) begin
      if (audio_out) begin
        highs++;
        if (first < 0) first = k;
        if (!prev) runs++;
      end
      prev = audio_out;
      if (k == s1) begin
        sample_in = v1; sample_valid = 1'b1;
      end else if (k == s2) begin
        sample_in = v2; sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  int cyc, high0, h, f, r, b;

  initial begin
    errors = 0; n_checks = 0;
    rst = 1'b1; sample_in = 8'h00; sample_valid = 1'b0; sd_mode = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({audio_out, period_strobe, underrun}), 0);
    #2 rst = 1'b0;

    // Soft start with no samples, then starvation.
    cyc = 0; high0 = 0;
    while (!m.run && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 256 && audio_out) high0++;
    end
    check("ramp_cycles", cyc, 32768);
    check("period0_highs", high0, 0);
    check("state_run", int'(dut.r_state), int'(RUN));
    check("active_mid", int'(dut.r_active), 128);
    while (!underrun && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("underrun_rise_cycle", cyc, 33792);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", int'(underrun), 0);

    measure(100, 8'h40, -1, 8'h00, h, f, r);
    check("mid_highs", h, 128);
    check("mid_first", f, 1);
    measure(50, 8'h10, 150, 8'hF0, h, f, r);
    check("pwm40_highs", h, 64);
    check("pwm40_first", f, 1);
    check("pwm40_runs", r, 1);
    check("pwm40_no_underrun", int'(underrun), 0);
    measure(255, 8'h20, -1, 8'h00, h, f, r);
    check("newest_highs", h, 240);
    check("newest_runs", r, 1);
    check("bnd_pend_full", int'(dut.r_pend_full), 0);
    sd_mode = 1'b1;
    measure(-1, 8'h00, -1, 8'h00, h, f, r);
    check("bnd_sample_highs", h, 32);
    measure(100, 8'h80, -1, 8'h00, h, f, r);
    check("pre_sd_highs", h, 32);
    measure(100, 8'h40, -1, 8'h00, h, f, r);
    check("sd80_highs", h, 128);
    check("sd80_first", f, 2);
    check("sd80_runs", r, 128);
    measure(-1, 8'h00, -1, 8'h00, h, f, r);
    check("sd40_highs", h, 64);
    check("sd40_first", f, 4);
    check("sd40_runs", r, 64);

    // Underrun set and clear on the same edge.
    b = 0;
    while (!(m.cnt == 8'd255 && m.miss == 4'd3) && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("pre_coincide_underrun", int'(underrun), 0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("set_beats_clear", int'(underrun), 1);

    // Reset mid-period while running PWM.
    sd_mode = 1'b0;
    go_to(8'd255);
    go_to(8'd10);
    check("pre_rst_out", int'(audio_out), 1);
    check("pre_rst_underrun", int'(underrun), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_out", int'(audio_out), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_active", int'(dut.r_active), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    measure(-1, 8'h00, -1, 8'h00, h, f, r);
    check("rst_period0_highs", h, 0);
    measure(-1, 8'h00, -1, 8'h00, h, f, r);
    check("rst_period1_highs", h, 1);
    check("rst_period1_first", f, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
